load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator-side block between the execute stage and the word-organised synchronous data memory. It issues the memory requests itself rather than answering them.
- Accepts one load/store request at a time from the pipeline, using the same 3-bit size/sign encoding as the memory control field.
- Generates word-aligned addresses, byte strobes and lane-shifted store data toward memory.
- Splits accesses that cross a word boundary into two beats, reassembles and sign/zero-extends load data, and returns a registered response.

Parameters:
- ADDRESS_WIDTH, 32, byte address width; word address wraps modulo 2^ADDRESS_WIDTH.
- DATA_WIDTH, 32, data bus width; only 32 is supported, and elaboration must fail otherwise.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_store  in  1  1 = store, 0 = load.
- req_op  in  3  size/sign encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_err  out  1  qualifies resp_valid; illegal op.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write; only meaningful with mem_en.
- mem_addr  out  ADDRESS_WIDTH  word-aligned byte address, bits [1:0] = 00.
- mem_wstrb  out  4  byte-lane write enables.
- mem_wdata  out  DATA_WIDTH  lane-positioned store data.
- mem_rdata  in  DATA_WIDTH  read word, valid the cycle after mem_en with mem_we = 0.

Behaviour:
- Reset (rst_n low at an edge):
  - state <= IDLE; resp_valid, resp_err, resp_rdata <= 0; latched request cleared.
  - mem_en, mem_we, mem_wstrb are 0 whenever state is IDLE or CAPTURE.
  - Reset mid-operation abandons outstanding beats. A split store may be left half-written, which is architecturally accepted. No resp_valid is issued for the abandoned request.
- Acceptance (IDLE):
  - Latch store flag, op, address, data, and offset o = addr[1:0].
  - Illegal requests are: op in {011, 110, 111}, or a store with op 100/101.
  - Legal request -> BEAT0. Illegal request -> CAPTURE with err flag set; no memory access.
- Lane rules:
  - Size mask: 0001 for b, 0011 for h, 1111 for w.
  - S8 = {4'b0, mask} << o.
  - D64 = {32'b0, wdata} << 8*o.
  - split = (S8[7:4] != 0).
- BEAT0:
  - mem_en = 1, mem_we = store, mem_addr = {addr[AW-1:2], 00}.
  - Store: mem_wstrb = S8[3:0], mem_wdata = D64[31:0]. Load: mem_wstrb = 0.
  - Next state: BEAT1 if split, else CAPTURE.
- BEAT1:
  - mem_en = 1, mem_addr = word address + 4, wrapping.
  - Store: mem_wstrb = S8[7:4], mem_wdata = D64[63:32].
  - Load: capture mem_rdata (beat-0 data) into lo_q.
  - Next state: CAPTURE.
- CAPTURE:
  - Last-beat load data on mem_rdata. Form W64 = split ? {mem_rdata, lo_q} : {32'b0, mem_rdata}.
  - Take X = W64 >> 8*o. Extend X[7:0] or X[15:0] with sign for b/h, zero for bu/hu; w passes X[31:0].
  - Register resp_rdata (0 for store/err), resp_err <= err, resp_valid <= 1.
  - Next state: IDLE.
- resp_valid is high exactly one cycle, the first IDLE cycle after CAPTURE. A new request may be accepted in that same cycle.
- Latency from accept edge to resp_valid:
  - Aligned: 3 cycles.
  - Split: 4 cycles.
  - Error: 2 cycles.
- Inputs are ignored while req_ready = 0. Changes to req_* outside the acceptance cycle have no effect.

Decomposition:
- Shared package lsu_pkg holds:
  - enum for op codes: OP_B=000, OP_H=001, OP_W=010, OP_BU=100, OP_HU=101.
  - FSM state enum: IDLE, BEAT0, BEAT1, CAPTURE.
  - size-mask function.
- Sub-module lsu_align is purely combinational and contains:
  - strobe/data shifting: S8, D64, split.
  - load extraction and extension from W64, o and op.
- lsu_align is reused by the future data-cache fill path.

Test Plan:
- Aligned load: mem[0x100] = 0xDEADBEEF, lw 0x100 -> one read at 0x100; resp_valid 3 cycles after accept; rdata 0xDEADBEEF; err 0.
- Byte loads: mem[0x100] = 0x80112233. lb 0x103 -> rdata 0xFFFFFF80. lbu 0x103 -> rdata 0x00000080. lh 0x102 -> rdata 0xFFFF8011.
- Aligned halfword store: sh 0x102, wdata 0x1234ABCD -> single write, addr 0x100, wstrb 1100, mem_wdata[31:16] = 0xABCD; resp_valid with rdata 0.
- Split load: mem[0x100] = 0x44332211, mem[0x104] = 0x88776655, lw 0x101 -> reads at 0x100 then 0x104; rdata 0x55443322; latency 4. A back-to-back request accepted in the resp_valid cycle is serviced correctly.
- Split store with address wrap: sw 0xFFFFFFFE, wdata 0xAABBCCDD produces two writes:
  - beat 0: addr 0xFFFFFFFC, wstrb 1100, data 0xCCDD0000.
  - beat 1: addr 0x00000000, wstrb 0011, data 0x0000AABB.
- Errors and reset:
  - op 011 -> mem_en never asserted; resp_valid with resp_err = 1 two cycles after accept.
  - Separately, rst_n low during BEAT1 of a split lw -> next cycle IDLE, req_ready = 1, no resp_valid, mem_en = 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit and its alignment helper.
//   lsu_op_e     : size/sign encoding shared with the memory control field
//   lsu_state_e  : request sequencing states of the load/store unit
//   size_mask()  : byte-lane mask of an access before it is shifted by offset
//   op_illegal() : flags encodings that must not reach memory
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT0   = 2'd1,
    BEAT1   = 2'd2,
    CAPTURE = 2'd3
  } lsu_state_e;

  // Only the low two op bits carry the size; bit 2 is the unsigned flag.
  // Reserved sizes fall into the word mask but are rejected before use.
  function automatic logic [3:0] size_mask(input logic [2:0] op);
    case (op[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Unsigned variants only make sense for loads, so a store using them
  // is rejected along with the reserved encodings.
  function automatic logic op_illegal(input logic [2:0] op, input logic store);
    case (op)
      OP_B, OP_H, OP_W: op_illegal = 1'b0;
      OP_BU, OP_HU:     op_illegal = store;
      default:          op_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering shared by the load/store unit and the
// data-cache fill path.
//   op      in  3   size/sign encoding
//   offset  in  2   byte offset inside the first word
//   wdata   in  32  right-justified store data
//   w64     in  64  two-word load window {second word, first word}
//   strb64  out 8   byte strobes across the two-word window
//   data64  out 64  store data positioned across the two-word window
//   split   out 1   access touches the second word
//   rdata   out 32  extracted and extended load data
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [63:0] w64,
  output logic [7:0]  strb64,
  output logic [63:0] data64,
  output logic        split,
  output logic [31:0] rdata
);

  logic [4:0]  shamt;
  logic [31:0] x;

  // Everything is expressed over a two-word window so an access that runs
  // past the end of the first word simply lands in the upper half.
  assign shamt  = {offset, 3'b000};
  assign strb64 = {4'b0000, size_mask(op)} << offset;
  assign data64 = {32'b0, wdata} << shamt;
  assign split  = |strb64[7:4];
  assign x      = 32'(w64 >> shamt);

  // Sign- or zero-extend the selected bytes; bit 2 of the op picks unsigned.
  always_comb begin
    rdata = x;
    case (op)
      OP_B:    rdata = {{24{x[7]}}, x[7:0]};
      OP_BU:   rdata = {24'b0, x[7:0]};
      OP_H:    rdata = {{16{x[15]}}, x[15:0]};
      OP_HU:   rdata = {16'b0, x[15:0]};
      default: rdata = x;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Initiator between the execute stage and a word-organised synchronous data
// memory. Takes one request at a time, splits word-crossing accesses into two
// beats, and returns a registered one-cycle response.
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_store, req_op          store flag and size/sign encoding
//   req_addr, req_wdata        byte address and right-justified store data
//   resp_valid/err/rdata       registered response pulse
//   mem_en, mem_we, mem_addr   memory access controls (word-aligned address)
//   mem_wstrb, mem_wdata       byte-lane write enables and positioned data
//   mem_rdata                  read word, valid the cycle after a read
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [3:0]               mem_wstrb,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  if (DATA_WIDTH != 32) begin : g_data_width_check
    $error("load_store_unit supports DATA_WIDTH = 32 only");
  end

  lsu_state_e               state;
  logic                     store_q;
  logic                     err_q;
  logic [2:0]               op_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    lo_q;

  logic [ADDRESS_WIDTH-1:0] word_addr;
  logic [7:0]               strb64;
  logic [2*DATA_WIDTH-1:0]  data64;
  logic                     split;
  logic [2*DATA_WIDTH-1:0]  w64;
  logic [DATA_WIDTH-1:0]    load_data;

  assign req_ready = (state == IDLE);
  assign word_addr = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};

  // In CAPTURE the last beat's word is on mem_rdata; for a split load the
  // first word was parked in lo_q during BEAT1.
  assign w64 = split ? {mem_rdata, lo_q} : {{DATA_WIDTH{1'b0}}, mem_rdata};

  lsu_align u_align (
    .op     (op_q),
    .offset (addr_q[1:0]),
    .wdata  (wdata_q),
    .w64    (w64),
    .strb64 (strb64),
    .data64 (data64),
    .split  (split),
    .rdata  (load_data)
  );

  // Memory controls are decoded from the registered state and latched
  // request, so they are quiet in IDLE and CAPTURE. The second beat's
  // address wraps naturally at the top of the address space.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = word_addr;
    mem_wstrb = 4'b0000;
    mem_wdata = '0;
    case (state)
      BEAT0: begin
        mem_en = 1'b1;
        mem_we = store_q;
        if (store_q) begin
          mem_wstrb = strb64[3:0];
          mem_wdata = data64[DATA_WIDTH-1:0];
        end
      end
      BEAT1: begin
        mem_en   = 1'b1;
        mem_we   = store_q;
        mem_addr = word_addr + ADDRESS_WIDTH'(4);
        if (store_q) begin
          mem_wstrb = strb64[7:4];
          mem_wdata = data64[2*DATA_WIDTH-1:DATA_WIDTH];
        end
      end
      default: ;
    endcase
  end

  // Request sequencing. A request is latched in IDLE and walked through one
  // or two memory beats; illegal ones skip memory and go straight to
  // CAPTURE. Reset abandons any outstanding beats without a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      err_q      <= 1'b0;
      op_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      lo_q       <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q <= req_store;
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= op_illegal(req_op, req_store);
            state   <= op_illegal(req_op, req_store) ? CAPTURE : BEAT0;
          end
        end
        BEAT0: begin
          state <= split ? BEAT1 : CAPTURE;
        end
        BEAT1: begin
          if (!store_q) begin
            lo_q <= mem_rdata;
          end
          state <= CAPTURE;
        end
        CAPTURE: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= (store_q || err_q) ? '0 : load_data;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
